sample_pacer: RTL

SAMPLE_PACER -- requirements
Module: sample_pacer

---
 rtl/sample_pacer_if.sv | 25 ++
 rtl/sample_pacer.sv | 127 ++++++++++++
 2 files changed

// File: rtl/sample_pacer_if.sv
// Sample stream bundle: upstream push handshake in, paced sample stream and status out.
interface sample_pacer_if #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 16
);
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_strobe;
  logic [LVL_W-1:0]  level;
  logic              underrun;

  modport slave (
    input  s_data, s_valid,
    output s_ready, m_data, m_strobe, level, underrun
  );

  modport master (
    output s_data, s_valid,
    input  s_ready, m_data, m_strobe, level, underrun
  );
endinterface

// File: rtl/sample_pacer.sv
// Buffers upstream samples in a FIFO and releases one per rising edge of a selected
// sample-rate square wave, after an initial prefill; flags strobes that find the FIFO empty.
module sample_pacer #(
  parameter int DATA_W  = 16,
  parameter int DEPTH   = 16,
  parameter int PREFILL = 8
) (
  input  logic       clock_in,
  input  logic       rst_in,
  input  logic [7:0] samp_rates,
  input  logic [2:0] rate_sel,
  sample_pacer_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] DEPTH_L   = LVL_W'(DEPTH);
  localparam logic [LVL_W-1:0] PREFILL_L = LVL_W'(PREFILL);

  typedef enum logic {FILL, RUN} state_e;

  state_e             state_q, state_d;
  logic [2:0]         sel_q;
  logic               sel_line_q, sel_prev_q;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [DATA_W-1:0]  mem [0:DEPTH-1];
  logic [DATA_W-1:0]  m_data_q;
  logic               m_strobe_q, underrun_q;

  logic sel_chg, tick, push, pop, strobe_d, starve;

  // A rate switch reloads both edge-detect stages, so its own cycle must not act on a stale tick.
  assign sel_chg = (rate_sel != sel_q);
  assign tick    = sel_line_q & ~sel_prev_q & ~sel_chg;
  assign push    = bus.s_valid & bus.s_ready;

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    starve   = 1'b0;
    strobe_d = 1'b0;
    if (sel_chg) begin
      state_d = FILL;
    end else begin
      case (state_q)
        FILL: begin
          if (level_q >= PREFILL_L) state_d = RUN;
        end
        RUN: begin
          if (tick) begin
            strobe_d = 1'b1;
            // Uses the registered level: a same-edge push into an empty FIFO still starves.
            if (level_q != '0) begin
              pop = 1'b1;
            end else begin
              starve  = 1'b1;
              state_d = FILL;
            end
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  always_comb begin
    level_d = level_q;
    case ({push, pop})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (rst_in) begin
      state_q <= FILL;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clock_in) begin
    if (rst_in) begin
      sel_q      <= rate_sel;
      sel_line_q <= samp_rates[rate_sel];
      sel_prev_q <= samp_rates[rate_sel];
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      m_data_q   <= '0;
      m_strobe_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      level_q    <= level_d;
      m_strobe_q <= strobe_d;
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (pop) begin
        m_data_q <= mem[rd_ptr_q];
      end else if (starve) begin
        m_data_q <= '0;
      end
      if (sel_chg) begin
        sel_q      <= rate_sel;
        sel_line_q <= samp_rates[rate_sel];
        sel_prev_q <= samp_rates[rate_sel];
        underrun_q <= 1'b0;
      end else begin
        sel_line_q <= samp_rates[sel_q];
        sel_prev_q <= sel_line_q;
        if (starve) underrun_q <= 1'b1;
      end
    end
  end

  // Sample storage is left unreset so it maps onto block RAM.
  always_ff @(posedge clock_in) begin
    if (push) mem[wr_ptr_q] <= bus.s_data;
  end

  assign bus.s_ready  = (level_q < DEPTH_L);
  assign bus.m_data   = m_data_q;
  assign bus.m_strobe = m_strobe_q;
  assign bus.level    = level_q;
  assign bus.underrun = underrun_q;
endmodule
